// File: rtl/lcd_lh507x_seq.sv
// LH507x-style LCD timing generator and pixel sequencer.
// Every output except px_ready is registered one clock after the counter state it decodes.
module lcd_lh507x_seq #(
  parameter int H_TOTAL  = 456,
  parameter int H_START  = 4,
  parameter int H_ACTIVE = 160,
  parameter int HS_W     = 8,
  parameter int LATCH_W  = 2,
  parameter int V_ACTIVE = 144,
  parameter int V_TOTAL  = 154
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       px_valid,
  input  logic [1:0] px_data,
  output logic       px_ready,
  input  logic       underrun_clr,
  output logic       hsync,
  output logic       vsync,
  output logic       latch,
  output logic       altsig,
  output logic       ctrl,
  output logic       pclk,
  output logic [1:0] data,
  output logic       frame_start,
  output logic       underrun
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BEG     = HW'(H_START);
  localparam logic [HW-1:0] H_END     = HW'(H_START + 2 * H_ACTIVE);
  localparam logic [HW-1:0] HS_END    = HW'(HS_W);
  localparam logic [HW-1:0] LATCH_END = HW'(LATCH_W);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);

  logic          running_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          latch_q, latch_d;
  logic          altsig_q, altsig_d;
  logic          ctrl_q, ctrl_d;
  logic          pclk_q, pclk_d;
  logic [1:0]    data_q, data_d;
  logic          frame_start_q, frame_start_d;
  logic          underrun_q, underrun_d;

  logic          active;
  logic          in_win;
  logic [HW-1:0] phase;

  // Dropping enable zeroes outputs and counters on the very next edge, without waiting for running to fall.
  assign active   = running_q & enable;
  assign phase    = hcnt_q - H_BEG;
  assign in_win   = running_q && (vcnt_q < V_ACT) && (hcnt_q >= H_BEG) && (hcnt_q < H_END);
  assign px_ready = in_win & ~phase[0];

  always_comb begin
    hcnt_d        = '0;
    vcnt_d        = '0;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    latch_d       = 1'b0;
    altsig_d      = 1'b0;
    ctrl_d        = 1'b0;
    pclk_d        = 1'b0;
    data_d        = 2'b00;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;

    if (active) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
      end
      hsync_d       = (hcnt_q < HS_END);
      vsync_d       = (vcnt_q == '0);
      latch_d       = (hcnt_q < LATCH_END) && (vcnt_q != '0) && (vcnt_q <= V_ACT);
      altsig_d      = altsig_q ^ ((hcnt_q == '0) && (vcnt_q != '0));
      ctrl_d        = 1'b1;
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
      // Even phase samples a new pixel; odd phase raises pclk while the pixel is held.
      if (in_win) begin
        if (phase[0]) begin
          pclk_d = 1'b1;
          data_d = data_q;
        end else begin
          data_d = px_valid ? px_data : 2'b00;
        end
      end
    end

    if (underrun_clr || !enable) underrun_d = 1'b0;
    if (active && px_ready && !px_valid) underrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q     <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      latch_q       <= 1'b0;
      altsig_q      <= 1'b0;
      ctrl_q        <= 1'b0;
      pclk_q        <= 1'b0;
      data_q        <= 2'b00;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      running_q     <= enable;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      latch_q       <= latch_d;
      altsig_q      <= altsig_d;
      ctrl_q        <= ctrl_d;
      pclk_q        <= pclk_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign latch       = latch_q;
  assign altsig      = altsig_q;
  assign ctrl        = ctrl_q;
  assign pclk        = pclk_q;
  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_lcd_lh507x_seq.sv
// Scoreboard bench for lcd_lh507x_seq on a shrunken panel geometry; the reference model
// derives every output from the cycle count since the panel started running.
module tb_lcd_lh507x_seq;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HA  = 12;
  localparam int HSW = 3;
  localparam int LW  = 2;
  localparam int VA  = 6;
  localparam int VT  = 9;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset, enable, px_valid, underrun_clr;
  logic [1:0] px_data;
  logic       px_ready, hsync, vsync, latch, altsig, ctrl, pclk, frame_start, underrun;
  logic [1:0] data;

  lcd_lh507x_seq #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .HS_W(HSW),
    .LATCH_W(LW), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready), .underrun_clr(underrun_clr), .hsync(hsync), .vsync(vsync),
    .latch(latch), .altsig(altsig), .ctrl(ctrl), .pclk(pclk), .data(data),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [10:0] expQ[$];

  // Reference model state: cycles since running started, and the registered outputs expected next.
  bit         runM = 0;
  int         t = 0;
  logic       unM = 1'b0;
  logic [1:0] dataM = 2'b00;
  logic [9:0] prevRegs = '0;
  bit         lastXfer = 0;

  function automatic bit winAt(int tt);
    int h, ln;
    h  = tt % HT;
    ln = (tt / HT) % VT;
    return (ln < VA) && (h >= HS) && (h < HS + 2 * HA);
  endfunction

  function automatic bit evenAt(int tt);
    return (((tt % HT) - HS) % 2) == 0;
  endfunction

  task automatic checkOutput(input string name, input logic [10:0] actual, input logic [10:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b (px_ready,hs,vs,latch,alt,ctrl,pclk,data,fs,underrun)",
               name, $time, actual, expected);
    end
  endtask

  task automatic stepModel();
    bit         act, inWin, even, pxr;
    int         h, ln, fr;
    logic       hs, vs, lat, alt, pc, fs;
    logic [1:0] nd;
    if (reset) begin
      runM = 0; t = 0; unM = 1'b0; dataM = 2'b00; lastXfer = 0;
      expQ.push_back(11'b0);
      prevRegs = '0;
      return;
    end
    h  = t % HT;
    ln = (t / HT) % VT;
    fr = t / FRAME;
    inWin = runM && winAt(t);
    even  = evenAt(t);
    pxr   = inWin && even;
    expQ.push_back({pxr, prevRegs});
    act = runM && enable;
    hs  = h < HSW;
    vs  = ln == 0;
    lat = (h < LW) && (ln >= 1) && (ln <= VA);
    alt = ((fr * (VT - 1) + ln) % 2) == 1;
    fs  = (h == 0) && (ln == 0);
    pc  = inWin && !even;
    nd  = !inWin ? 2'b00 : (even ? (px_valid ? px_data : 2'b00) : dataM);
    if (act && pxr && !px_valid) unM = 1'b1;
    else if (underrun_clr || !enable) unM = 1'b0;
    dataM    = act ? nd : 2'b00;
    prevRegs = act ? {hs, vs, lat, alt, 1'b1, pc, nd, fs, unM} : {9'b0, unM};
    lastXfer = pxr && px_valid;
    t    = act ? t + 1 : 0;
    runM = enable;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic v, input logic clr, input bit seqMode);
    @(negedge clk);
    reset        = rst;
    enable       = en;
    px_valid     = v;
    underrun_clr = clr;
    if (lastXfer) px_data = seqMode ? px_data + 2'd1 : 2'($urandom_range(0, 3));
    stepModel();
  endtask

  task automatic randomStimulus();
    applyStimulus(1'b0, $urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 19) == 0, 1'b0);
  endtask

  task automatic waitForPixel();
    int n = 0;
    while (!(runM && winAt(t) && evenAt(t)) && n < 5000) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 5000) checkOutput("wait_pixel_timeout", 11'h7ff, 11'h000);
  endtask

  // Monitor: pops one expectation per cycle, decoupled from the stimulus process.
  initial begin
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("cycle", {px_ready, hsync, vsync, latch, altsig, ctrl, pclk, data, frame_start, underrun}, exp);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; px_valid = 1'b0; underrun_clr = 1'b0; px_data = 2'b00;
    $display("[TB] start");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Constant valid stream with a 0,1,2,3 pixel sequence over two frames.
    repeat (2 * FRAME + 10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Underrun on one pixel, then clear, then coincident set and clear.
    waitForPixel();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    waitForPixel();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Disable mid-line on line 5, hcnt 20, then re-enable for a fresh frame.
    n = 0;
    while (!(runM && (t % FRAME) == 5 * HT + 20) && n < 2 * FRAME) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 2 * FRAME) checkOutput("wait_disable_timeout", 11'h7ff, 11'h000);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (FRAME + 5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (4 * FRAME) randomStimulus();

    // Asynchronous reset in the middle of the pixel window, away from any clock edge.
    waitForPixel();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkOutput("async_reset", {px_ready, hsync, vsync, latch, altsig, ctrl, pclk, data, frame_start, underrun}, 11'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (FRAME + 10) randomStimulus();

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
